dac_spi_out: RTL and testbench

//  Downstream stage of the wave generators: takes the live 12-bit sample and its ofs_kill flag.

---
 rtl/dac_spi_out.sv | 201 ++++++++++++++++++++
 tb/tb_dac_spi_out.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_out.sv
// dac_spi_out
//   Output stage for the wave generators. It captures one sample, scales it by an
//   unsigned Q2.14 gain and adds a signed offset. The result is saturated to 12 bits.
//   The code is shifted out as a 16-bit SPI frame {DAC_CFG, code}, MSB first, in mode 0.
//   LDAC is then pulsed so the DAC updates. Frames repeat back-to-back while enable is high.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   enable     in   start/continue frames; low = stop after the current frame
//   sample     in   12-bit unsigned sample
//   ofs_kill   in   1 = generator active, 0 = send IDLE_CODE
//   gain       in   16-bit unsigned Q2.14 gain (16384 = 1.0)
//   offset     in   13-bit signed code offset
//   cs_n       out  DAC chip select, active low
//   sclk       out  SPI clock, idle low
//   mosi       out  SPI data, MSB first
//   ldac_n     out  DAC latch strobe, active low
//   busy       out  high whenever the FSM is not in IDLE
//   frame_done out  one-cycle pulse in the last GAP cycle
module dac_spi_out #(
    parameter int          CLK_DIV   = 2,
    parameter logic [3:0]  DAC_CFG   = 4'b0011,
    parameter logic [11:0] IDLE_CODE = 12'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] sample,
    input  logic        ofs_kill,
    input  logic [15:0] gain,
    input  logic [12:0] offset,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    output logic        ldac_n,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_SHIFT, S_LATCH, S_GAP} state_t;

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          phase, phase_next;     // 0 = sclk low half, 1 = sclk high half
    logic [3:0]    bit_cnt, bit_next;
    logic          sclk_next, mosi_next;
    logic          capture, load, shift;

    logic [11:0]        sample_p0;
    logic               kill_p0;
    logic [15:0]        gain_p0;
    logic [12:0]        offset_p0;
    logic [27:0]        prod_p1;
    logic signed [15:0] sum_p1;
    logic [11:0]        code_p1;
    logic [15:0]        shreg;

    function automatic logic [11:0] sat12(input logic signed [15:0] v);
        if (v < 16'sd0)
            return 12'd0;
        else if (v > 16'sd4095)
            return 12'd4095;
        else
            return v[11:0];
    endfunction

    // (prod >> 14) is at most 16380, so 16-bit signed arithmetic cannot overflow.
    assign sum_p1  = $signed({2'b00, prod_p1[27:14]}) + $signed({{3{offset_p0[12]}}, offset_p0});
    assign code_p1 = kill_p0 ? sat12(sum_p1) : IDLE_CODE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            phase   <= 1'b0;
            bit_cnt <= 4'd0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            ldac_n  <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            phase   <= phase_next;
            bit_cnt <= bit_next;
            sclk    <= sclk_next;
            mosi    <= mosi_next;
            // Strobes are registered from the next state so they are glitch-free pins.
            cs_n    <= (state_next != S_SHIFT);
            ldac_n  <= (state_next != S_LATCH);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        phase_next = phase;
        bit_next   = bit_cnt;
        sclk_next  = sclk;
        mosi_next  = mosi;
        capture    = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        frame_done = 1'b0;
        busy       = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                cnt_next   = '0;
                phase_next = 1'b0;
                bit_next   = 4'd0;
                if (enable) begin
                    capture    = 1'b1;
                    state_next = S_MUL;
                end
            end
            S_MUL: state_next = S_ADD;
            S_ADD: begin
                load       = 1'b1;
                mosi_next  = DAC_CFG[3];     // first bit is valid as cs_n falls
                cnt_next   = '0;
                phase_next = 1'b0;
                bit_next   = 4'd0;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_next = '0;
                    if (!phase) begin
                        phase_next = 1'b1;
                        sclk_next  = 1'b1;
                    end else if (bit_cnt == 4'd15) begin
                        phase_next = 1'b0;
                        sclk_next  = 1'b0;
                        mosi_next  = 1'b0;
                        state_next = S_LATCH;
                    end else begin
                        // Falling sclk: advance to the next bit.
                        phase_next = 1'b0;
                        sclk_next  = 1'b0;
                        shift      = 1'b1;
                        mosi_next  = shreg[14];
                        bit_next   = bit_cnt + 4'd1;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_LATCH: begin
                if (cnt == DIV_LAST) begin
                    cnt_next   = '0;
                    state_next = S_GAP;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == DIV_LAST) begin
                    cnt_next   = '0;
                    frame_done = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_p0 <= 12'd0;
            kill_p0   <= 1'b0;
            gain_p0   <= 16'd0;
            offset_p0 <= 13'd0;
            prod_p1   <= 28'd0;
            shreg     <= 16'd0;
        end else begin
            // capture stage: the only point where the inputs are sampled
            if (capture) begin
                sample_p0 <= sample;
                kill_p0   <= ofs_kill;
                gain_p0   <= gain;
                offset_p0 <= offset;
            end
            // multiply stage
            if (state == S_MUL)
                prod_p1 <= 28'(sample_p0) * 28'(gain_p0);
            // offset/saturate stage feeds the shift register
            if (load)
                shreg <= {DAC_CFG, code_p1};
            else if (shift)
                shreg <= {shreg[14:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_dac_spi_out.sv
module tb_dac_spi_out;

    logic        clk = 1'b0;
    logic        reset, enable, ofs_kill;
    logic [11:0] sample;
    logic [15:0] gain;
    logic [12:0] offset;
    logic        cs_n, sclk, mosi, ldac_n, busy, frame_done;

    int tests = 0;
    int fails = 0;
    int cs_falls = 0;
    int ld_pulses = 0;
    int frames_pushed = 0;
    logic [15:0] expq[$];

    always #5 clk = ~clk;

    dac_spi_out #(.CLK_DIV(2), .DAC_CFG(4'b0011), .IDLE_CODE(12'd0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample(sample),
        .ofs_kill(ofs_kill), .gain(gain), .offset(offset),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .ldac_n(ldac_n),
        .busy(busy), .frame_done(frame_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_in(input int s, input int k, input int g, input int o);
        sample   = 12'(s);
        ofs_kill = 1'(k);
        gain     = 16'(g);
        offset   = 13'(o);
    endtask

    task automatic expect_frame(input logic [15:0] w);
        expq.push_back(w);
        frames_pushed++;
    endtask

    // Starts one frame (also releases reset in the same cycle), drops enable in MUL,
    // and waits for the frame to finish.
    task automatic run_frame(input bit scramble, output int busy_cycles, output int fd_idx);
        int w;
        int n;
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!busy && w < 10);
        chk("capture_latency", w, 1);
        enable = 1'b0;
        n = 0;
        fd_idx = -1;
        busy_cycles = 0;
        while (busy && n < 300) begin
            if (frame_done) fd_idx = n;
            busy_cycles++;
            if (scramble) begin
                sample   = 12'($urandom);
                gain     = 16'($urandom);
                offset   = 13'($urandom);
                ofs_kill = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        chk("frame_timeout_busy", int'(busy), 0);
    endtask

    // Monitor: reassembles each SPI frame and checks it against the scoreboard.
    initial begin
        logic [15:0] word;
        int nb, cs_cnt, ld_cnt;
        logic prev_cs, prev_sclk, prev_ld;
        logic [15:0] exp_w;
        word = 16'd0; nb = 0; cs_cnt = 0; ld_cnt = 0;
        prev_cs = 1'b1; prev_sclk = 1'b0; prev_ld = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                word = 16'd0; nb = 0; cs_cnt = 0; ld_cnt = 0;
                prev_cs = 1'b1; prev_sclk = 1'b0; prev_ld = 1'b1;
            end else begin
                if (!cs_n && prev_cs) begin
                    cs_falls++;
                    word = 16'd0; nb = 0; cs_cnt = 0;
                end
                if (!cs_n) begin
                    cs_cnt++;
                    if (sclk && !prev_sclk) begin
                        word = {word[14:0], mosi};
                        nb++;
                    end
                end
                if (cs_n && !prev_cs) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        exp_w = expq.pop_front();
                        chk("frame_word", int'(word), int'(exp_w));
                    end
                    chk("sclk_rises", nb, 16);
                    chk("cs_low_cycles", cs_cnt, 64);
                end
                if (!ldac_n) ld_cnt++;
                if (ldac_n && !prev_ld) begin
                    chk("ldac_low_cycles", ld_cnt, 2);
                    ld_pulses++;
                    ld_cnt = 0;
                end
                prev_cs = cs_n; prev_sclk = sclk; prev_ld = ldac_n;
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bc, fd, w, n, lowc, pre, pulses_before;
        reset = 1'b1; enable = 1'b0;
        set_in(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_mosi", int'(mosi), 0);
        chk("rst_ldac_n", int'(ldac_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Unity gain, frame timing
        set_in(12'h5A5, 1, 16384, 0);
        expect_frame(16'h35A5);
        run_frame(0, bc, fd);
        chk("busy_cycles", bc, 70);
        chk("frame_done_idx", fd, 69);

        // Clipping high and low
        set_in(4000, 1, 32768, 0);    expect_frame(16'h3FFF); run_frame(0, bc, fd);
        set_in(100, 1, 16384, -200);  expect_frame(16'h3000); run_frame(0, bc, fd);
        // Positive offset, then idle code
        set_in(1000, 1, 16384, 50);   expect_frame(16'h341A); run_frame(0, bc, fd);
        set_in(1000, 0, 16384, 50);   expect_frame(16'h3000); run_frame(0, bc, fd);
        // Boundaries
        set_in(2000, 1, 0, 300);      expect_frame(16'h312C); run_frame(0, bc, fd);
        set_in(4095, 1, 16384, -4096); expect_frame(16'h3000); run_frame(0, bc, fd);
        set_in(4095, 1, 65535, 0);    expect_frame(16'h3FFF); run_frame(0, bc, fd);
        set_in(0, 1, 0, 4095);        expect_frame(16'h3FFF); run_frame(0, bc, fd);

        // Inputs churn after capture
        set_in(12'h123, 1, 16384, 0); expect_frame(16'h3123); run_frame(1, bc, fd);

        // Back-to-back frames with enable held high
        set_in(12'h0F0, 1, 16384, 0);
        expect_frame(16'h30F0); expect_frame(16'h30F0);
        @(negedge clk);
        enable = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!busy && w < 10);
        n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        lowc = 0;
        while (!busy && lowc < 10) begin lowc++; @(negedge clk); end
        chk("b2b_idle_cycles", lowc, 1);
        enable = 1'b0;
        n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        chk("b2b_second_busy_cycles", n, 70);

        // Quiet while disabled
        pre = cs_falls;
        repeat (30) @(negedge clk);
        chk("no_cs_when_disabled", cs_falls - pre, 0);
        chk("disabled_busy", int'(busy), 0);

        // Reset in the middle of SHIFT
        set_in(4095, 1, 16384, 0);
        @(negedge clk);
        enable = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!busy && w < 10);
        enable = 1'b0;
        n = 0;
        while (n < 31) begin @(negedge clk); n++; end
        chk("mid_frame_cs_low", int'(cs_n), 0);
        chk("mid_frame_mosi", int'(mosi), 1);
        pulses_before = ld_pulses;
        reset = 1'b1;
        #1;
        chk("abort_cs_n", int'(cs_n), 1);
        chk("abort_sclk", int'(sclk), 0);
        chk("abort_mosi", int'(mosi), 0);
        chk("abort_ldac_n", int'(ldac_n), 1);
        chk("abort_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("abort_no_ldac", ld_pulses - pulses_before, 0);
        set_in(12'h9C3, 1, 16384, 0);
        expect_frame(16'h39C3);
        run_frame(0, bc, fd);
        chk("post_reset_busy_cycles", bc, 70);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", expq.size(), 0);
        chk("ldac_pulse_count", ld_pulses, frames_pushed);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
